// File: rtl/rotate_left_seq_32_bit_if.sv
// Handshake and data bundle for the sequential 32-bit rotate-left unit.
// The master drives the request side; the slave returns the result and status.
interface rotate_left_seq_32_bit_if;
    logic        i_start;
    logic [31:0] i_in;
    logic [4:0]  i_num_rotate_bits;
    logic [31:0] o_out;
    logic        o_busy;
    logic        o_done;

    modport master (
        output i_start,
        output i_in,
        output i_num_rotate_bits,
        input  o_out,
        input  o_busy,
        input  o_done
    );

    modport slave (
        input  i_start,
        input  i_in,
        input  i_num_rotate_bits,
        output o_out,
        output o_busy,
        output o_done
    );
endinterface

// File: rtl/rotate_left_seq_32_bit.sv
// Multi-cycle 32-bit rotate-left: one bit position per clock, with a start/done handshake.
// The result register only updates when an operation completes.
module rotate_left_seq_32_bit (
    input  logic                     i_clock,
    input  logic                     i_clear,
    rotate_left_seq_32_bit_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROTATE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_work;
    logic [31:0] w_work_nxt;
    logic [4:0]  r_count;
    logic [4:0]  w_count_nxt;
    logic [31:0] r_out;
    logic [31:0] w_out_nxt;
    logic        r_busy;
    logic        r_done;
    logic [31:0] w_rot;

    assign w_rot = {r_work[31-1:0], r_work[31]};

    // State register, datapath registers and registered status flags.
    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_state <= ST_IDLE;
            r_work  <= 32'h0000_0000;
            r_count <= 5'd0;
            r_out   <= 32'h0000_0000;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_work  <= w_work_nxt;
            r_count <= w_count_nxt;
            r_out   <= w_out_nxt;
            r_busy  <= (w_state_nxt == ST_ROTATE);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    // Next-state and datapath update; start is only honoured outside ROTATE.
    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_count_nxt = r_count;
        w_out_nxt   = r_out;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.i_start) begin
                    w_work_nxt  = bus.i_in;
                    w_count_nxt = bus.i_num_rotate_bits;
                    if (bus.i_num_rotate_bits == 5'd0) begin
                        w_state_nxt = ST_DONE;
                        w_out_nxt   = bus.i_in;
                    end else begin
                        w_state_nxt = ST_ROTATE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ROTATE: begin
                w_work_nxt  = w_rot;
                w_count_nxt = r_count - 5'd1;
                // Last rotation step: publish the final value straight from the rotator.
                if (r_count == 5'd1) begin
                    w_state_nxt = ST_DONE;
                    w_out_nxt   = w_rot;
                end else begin
                    w_state_nxt = ST_ROTATE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_work_nxt  = 32'h0000_0000;
                w_count_nxt = 5'd0;
            end
        endcase
    end

    assign bus.o_out  = r_out;
    assign bus.o_busy = r_busy;
    assign bus.o_done = r_done;

endmodule
